// File: rtl/fft_input_buffer_pkg.sv
// Shared constants and types for the FFT input ping-pong buffer.
package fft_input_buffer_pkg;

    localparam int unsigned DataWidth = 24;
    localparam int unsigned FftPoints = 512;
    localparam int unsigned AddrWidth = $clog2(FftPoints);
    localparam int unsigned CntWidth  = 16;

    // Write-side FSM: filling a bank, or holding a full bank until the reader frees one.
    typedef enum logic [0:0] {
        StFill     = 1'b0,
        StFullWait = 1'b1
    } wr_state_e;

endpackage

// File: rtl/fft_sample_bank_ram.sv
// Two-bank sample store: one write port, one registered read port, address = {bank, ptr}.
module fft_sample_bank_ram #(
    parameter int unsigned DataWidth = 24,
    parameter int unsigned AddrWidth = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [DataWidth-1:0] rdata_o
);

    localparam int unsigned Depth = 1 << AddrWidth;

    logic [DataWidth-1:0] mem [Depth];
    logic [DataWidth-1:0] rdata_q;

    // Array write; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read, output register cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_input_buffer.sv
// Ping-pong frame buffer feeding fft_top: fills one bank while the FFT reads the other.
module fft_input_buffer
    import fft_input_buffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_sample_valid,
    input  logic [DataWidth-1:0] i_sample,
    input  logic [AddrWidth-1:0] i_read_addr,
    output logic [DataWidth-1:0] o_read_data,
    output logic                 o_data_ready,
    input  logic                 i_fft_busy,
    input  logic                 i_fft_done,
    output logic                 o_overrun,
    output logic [CntWidth-1:0]  o_dropped_count,
    output logic                 o_wr_bank
);

    localparam logic [AddrWidth-1:0] PtrLast = AddrWidth'(FftPoints - 1);
    localparam logic [CntWidth-1:0]  CntMax  = '1;

    wr_state_e            state_q, state_d;
    logic                 wr_bank_q, wr_bank_d;
    logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic                 locked_q, locked_d;
    logic                 ready_q, ready_d;
    logic                 overrun_q, overrun_d;
    logic [CntWidth-1:0]  drop_cnt_q, drop_cnt_d;

    logic                 swap;
    logic                 drop;
    logic                 wr_en;
    logic                 wr_sel_bank;

    // State register and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StFill;
            wr_bank_q  <= 1'b0;
            wr_ptr_q   <= '0;
            locked_q   <= 1'b0;
            ready_q    <= 1'b0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            wr_ptr_q   <= wr_ptr_d;
            locked_q   <= locked_d;
            ready_q    <= ready_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Next-state decode: decides writes, bank swaps and drops.
    always_comb begin
        state_d     = state_q;
        swap        = 1'b0;
        drop        = 1'b0;
        wr_en       = 1'b0;
        wr_sel_bank = wr_bank_q;
        unique case (state_q)
            StFill: begin
                if (i_sample_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr_q == PtrLast) begin
                        // A done in the same cycle frees the read bank just in time.
                        if (!locked_q || i_fft_done) begin
                            swap = 1'b1;
                        end else begin
                            state_d = StFullWait;
                        end
                    end
                end
            end
            StFullWait: begin
                if (i_fft_done) begin
                    swap    = 1'b1;
                    state_d = StFill;
                    // Coincident sample lands at address 0 of the bank we swap into.
                    if (i_sample_valid) begin
                        wr_en       = 1'b1;
                        wr_sel_bank = ~wr_bank_q;
                    end
                end else if (i_sample_valid) begin
                    drop = 1'b1;
                end
            end
        endcase
    end

    // Output/datapath next values derived from the decode above.
    always_comb begin
        wr_bank_d  = swap ? ~wr_bank_q : wr_bank_q;
        // Pointer is already 0 in FullWait (wrapped), so +1 also covers the coincident write.
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        locked_d   = swap ? 1'b1 : (locked_q && !i_fft_done);
        ready_d    = swap ? 1'b1 : (ready_q && !i_fft_busy && !i_fft_done);
        overrun_d  = drop;
        drop_cnt_d = (drop && drop_cnt_q != CntMax) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    end

    fft_sample_bank_ram #(
        .DataWidth(DataWidth),
        .AddrWidth(AddrWidth + 1)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we_i   (wr_en),
        .waddr_i({wr_sel_bank, wr_ptr_q}),
        .wdata_i(i_sample),
        .raddr_i({~wr_bank_q, i_read_addr}),
        .rdata_o(o_read_data)
    );

    assign o_data_ready    = ready_q;
    assign o_overrun       = overrun_q;
    assign o_dropped_count = drop_cnt_q;
    assign o_wr_bank       = wr_bank_q;

endmodule

// File: tb/tb_fft_input_buffer.sv
// Directed self-checking bench for fft_input_buffer.
module tb_fft_input_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_sample_valid;
    logic [23:0] i_sample;
    logic [8:0]  i_read_addr;
    logic [23:0] o_read_data;
    logic        o_data_ready;
    logic        i_fft_busy;
    logic        i_fft_done;
    logic        o_overrun;
    logic [15:0] o_dropped_count;
    logic        o_wr_bank;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fft_input_buffer u_dut (
        .clk            (clk),
        .reset          (reset),
        .i_sample_valid (i_sample_valid),
        .i_sample       (i_sample),
        .i_read_addr    (i_read_addr),
        .o_read_data    (o_read_data),
        .o_data_ready   (o_data_ready),
        .i_fft_busy     (i_fft_busy),
        .i_fft_done     (i_fft_done),
        .o_overrun      (o_overrun),
        .o_dropped_count(o_dropped_count),
        .o_wr_bank      (o_wr_bank)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs, then release strobes; outputs sampled 1ns after the edge.
    task automatic step(input logic v, input logic [23:0] d, input logic busy, input logic done);
        i_sample_valid = v;
        i_sample       = d;
        i_fft_busy     = busy;
        i_fft_done     = done;
        @(posedge clk);
        #1;
        i_sample_valid = 1'b0;
        i_fft_busy     = 1'b0;
        i_fft_done     = 1'b0;
    endtask

    task automatic read_at(input logic [8:0] a, output logic [23:0] d);
        i_read_addr = a;
        @(posedge clk);
        #1;
        d = o_read_data;
    endtask

    logic [23:0] rd;
    int          ovr_cnt;

    initial begin
        reset          = 1'b1;
        i_sample_valid = 1'b0;
        i_sample       = '0;
        i_read_addr    = '0;
        i_fft_busy     = 1'b0;
        i_fft_done     = 1'b0;
        #12;
        check_eq("rst_ready", o_data_ready, 0);
        check_eq("rst_wr_bank", o_wr_bank, 0);
        check_eq("rst_read_data", o_read_data, 0);
        check_eq("rst_dropped", o_dropped_count, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: first frame swaps without any handshake.
        for (int n = 0; n < 511; n++) step(1'b1, 24'(n), 1'b0, 1'b0);
        check_eq("t1_ready_before_last", o_data_ready, 0);
        step(1'b1, 24'd511, 1'b0, 1'b0);
        check_eq("t1_ready", o_data_ready, 1);
        check_eq("t1_wr_bank", o_wr_bank, 1);
        read_at(9'd37, rd);
        check_eq("t1_read37", rd, 37);

        // 2: busy clears ready; done mid-fill unlocks so the next frame swaps.
        step(1'b0, 24'd0, 1'b1, 1'b0);
        check_eq("t2_ready_clr", o_data_ready, 0);
        for (int n = 0; n < 512; n++) step(1'b1, 24'(1000 + n), 1'b0, (n == 256));
        check_eq("t2_ready", o_data_ready, 1);
        check_eq("t2_wr_bank", o_wr_bank, 0);
        read_at(9'd5, rd);
        check_eq("t2_read5", rd, 1005);

        // 3: overrun while locked, then done coincident with a sample.
        for (int n = 0; n < 512; n++) step(1'b1, 24'(2000 + n), 1'b0, 1'b0);
        check_eq("t3_no_swap", o_wr_bank, 0);
        check_eq("t3_no_ovr_last", o_overrun, 0);
        ovr_cnt = 0;
        for (int n = 0; n < 3; n++) begin
            step(1'b1, 24'(5000 + n), 1'b0, 1'b0);
            if (o_overrun) ovr_cnt++;
        end
        check_eq("t3_ovr_pulses", ovr_cnt, 3);
        check_eq("t3_dropped", o_dropped_count, 3);
        step(1'b1, 24'h7FFFFF, 1'b0, 1'b1);
        check_eq("t3_swap_bank", o_wr_bank, 1);
        check_eq("t3_no_ovr_done", o_overrun, 0);
        check_eq("t3_dropped_hold", o_dropped_count, 3);
        check_eq("t3_ready", o_data_ready, 1);
        read_at(9'd511, rd);
        check_eq("t3_old_frame511", rd, 2511);
        // Free the lock, fill the rest of bank 1 so it becomes readable.
        step(1'b0, 24'd0, 1'b0, 1'b1);
        for (int n = 1; n < 512; n++) step(1'b1, 24'(6000 + n), 1'b0, 1'b0);
        check_eq("t3_bank_back", o_wr_bank, 0);
        read_at(9'd0, rd);
        check_eq("t3_read0_max", rd, 24'h7FFFFF);
        read_at(9'd1, rd);
        check_eq("t3_read1", rd, 6001);

        // 4: last sample coincides with done while locked.
        step(1'b0, 24'd0, 1'b1, 1'b0);
        check_eq("t4_ready_clr", o_data_ready, 0);
        for (int n = 0; n < 511; n++) step(1'b1, 24'(7000 + n), 1'b0, 1'b0);
        step(1'b1, 24'd7511, 1'b0, 1'b1);
        check_eq("t4_ready", o_data_ready, 1);
        check_eq("t4_wr_bank", o_wr_bank, 1);
        check_eq("t4_no_ovr", o_overrun, 0);
        check_eq("t4_dropped", o_dropped_count, 3);

        // 5: async reset mid-frame discards the partial frame.
        for (int n = 0; n < 200; n++) step(1'b1, 24'(8000 + n), 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t5_rst_ready", o_data_ready, 0);
        check_eq("t5_rst_bank", o_wr_bank, 0);
        check_eq("t5_rst_ovr", o_overrun, 0);
        check_eq("t5_rst_dropped", o_dropped_count, 0);
        check_eq("t5_rst_rdata", o_read_data, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int n = 0; n < 512; n++) step(1'b1, 24'(3000 + n), 1'b0, 1'b0);
        check_eq("t5_ready", o_data_ready, 1);
        check_eq("t5_wr_bank", o_wr_bank, 1);
        read_at(9'd100, rd);
        check_eq("t5_read100", rd, 3100);

        // 6: saturate the drop counter; negative sample survives bit-exact.
        for (int n = 0; n < 511; n++) step(1'b1, 24'(n), 1'b0, 1'b0);
        step(1'b1, 24'h800000, 1'b0, 1'b0);
        for (int n = 0; n < 65534; n++) step(1'b1, 24'(n), 1'b0, 1'b0);
        check_eq("t6_cnt_fffe", o_dropped_count, 16'hFFFE);
        for (int n = 0; n < 6; n++) step(1'b1, 24'(n), 1'b0, 1'b0);
        check_eq("t6_cnt_sat", o_dropped_count, 16'hFFFF);
        check_eq("t6_ovr_at_sat", o_overrun, 1);
        step(1'b0, 24'd0, 1'b0, 1'b1);
        check_eq("t6_swap_bank", o_wr_bank, 0);
        read_at(9'd511, rd);
        check_eq("t6_read_neg", rd, 24'h800000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
